// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: fetch state encoding, instruction class field
// positions and the default reset vector.
package instruction_fetch_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      REQ,
      WAIT,
      HOLD
   } fetch_state_e;

   localparam int unsigned CLASS_MSB = 15;
   localparam int unsigned CLASS_LSB = 12;

   localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

   function automatic logic [CLASS_MSB-CLASS_LSB:0] instr_class(input logic [15:0] word);
      return word[CLASS_MSB:CLASS_LSB];
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory request/return plus the decode handoff.
interface instruction_fetch_unit_if #(
   parameter int unsigned PC_WIDTH    = 16,
   parameter int unsigned INSTR_WIDTH = 16
);

   logic [PC_WIDTH-1:0]    imem_addr;
   logic                   imem_rd;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   imem_rvalid;
   logic [INSTR_WIDTH-1:0] instr;
   logic [PC_WIDTH-1:0]    instr_pc;
   logic                   instr_valid;
   logic                   dec_ready;
   logic                   pc_increment;

   modport master (
      output imem_addr, imem_rd, instr, instr_pc, instr_valid,
      input  imem_rdata, imem_rvalid, dec_ready, pc_increment
   );

   modport slave (
      input  imem_addr, imem_rd, instr, instr_pc, instr_valid,
      output imem_rdata, imem_rvalid, dec_ready, pc_increment
   );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch stage: owns the PC, issues one outstanding imem read at a time
// and hands each word to decode over valid/ready; supports jumps and single-step.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned          PC_WIDTH     = 16,
   parameter int unsigned          INSTR_WIDTH  = 16,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic                  clock,
   input  logic                  reset,
   instruction_fetch_unit_if.master bus,
   input  logic                  jump_valid,
   input  logic [PC_WIDTH-1:0]   jump_target,
   input  logic                  step_mode,
   input  logic                  step_pulse,
   output logic [15:0]           retired_count
);

   fetch_state_e           state, state_nxt;
   logic [PC_WIDTH-1:0]    pc, pc_nxt;
   logic [INSTR_WIDTH-1:0] instr_q, instr_nxt;
   logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_nxt;
   logic                   valid_q, valid_nxt;
   logic [15:0]            retired_q, retired_nxt;
   logic                   discard, discard_nxt;
   fetch_state_e           resume;
   logic                   handoff;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_VECTOR;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         retired_q  <= '0;
         discard    <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         instr_q    <= instr_nxt;
         instr_pc_q <= instr_pc_nxt;
         valid_q    <= valid_nxt;
         retired_q  <= retired_nxt;
         discard    <= discard_nxt;
      end
   end

   // A jump pre-empts everything; an in-flight read becomes an orphan that must
   // still drain before the next request, so only one read is ever outstanding.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr_q;
      instr_pc_nxt = instr_pc_q;
      valid_nxt    = valid_q;
      retired_nxt  = retired_q;
      discard_nxt  = discard;
      resume       = step_mode ? STEP : REQ;
      handoff      = valid_q & bus.dec_ready;

      if (jump_valid) begin
         pc_nxt    = jump_target;
         valid_nxt = 1'b0;
         case (state)
            REQ: begin
               discard_nxt = 1'b1;
               state_nxt   = WAIT;
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  discard_nxt = 1'b0;
                  state_nxt   = resume;
               end else begin
                  discard_nxt = 1'b1;
               end
            end
            default: state_nxt = resume;
         endcase
      end else begin
         case (state)
            IDLE: state_nxt = resume;
            STEP: begin
               if (step_pulse) state_nxt = REQ;
            end
            REQ:  state_nxt = WAIT;
            WAIT: begin
               if (bus.imem_rvalid) begin
                  if (discard) begin
                     discard_nxt = 1'b0;
                     state_nxt   = resume;
                  end else begin
                     instr_nxt    = bus.imem_rdata;
                     instr_pc_nxt = pc;
                     valid_nxt    = 1'b1;
                     state_nxt    = HOLD;
                  end
               end
            end
            HOLD: begin
               if (handoff) begin
                  pc_nxt      = bus.pc_increment ? instr_pc_q + PC_WIDTH'(1) : instr_pc_q;
                  valid_nxt   = 1'b0;
                  retired_nxt = retired_q + 16'd1;
                  state_nxt   = resume;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.imem_rd     = (state == REQ);
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
   assign retired_count   = retired_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit with a transaction-level
// scoreboard and a variable-latency memory model returning addr ^ 16'hA5A5.
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        jump_valid;
   logic [15:0] jump_target;
   logic        step_mode;
   logic        step_pulse;
   logic [15:0] retired_count;

   instruction_fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus();

   instruction_fetch_unit #(
      .PC_WIDTH(16),
      .INSTR_WIDTH(16),
      .RESET_VECTOR(16'h0000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus),
      .jump_valid(jump_valid),
      .jump_target(jump_target),
      .step_mode(step_mode),
      .step_pulse(step_pulse),
      .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // scoreboard state
   logic [15:0] m_exp_addr = 16'h0000;
   logic        m_out = 1'b0;
   logic        m_orphan = 1'b0;
   logic [15:0] m_fetch_addr = 16'h0000;
   logic        m_hold = 1'b0;
   logic [15:0] m_held_pc = 16'h0000;
   logic [15:0] m_held_word = 16'h0000;
   logic [15:0] m_retired = 16'h0000;
   int unsigned gap = 0;
   logic        gap_en = 1'b1;

   // memory model
   logic        mem_pend = 1'b0;
   int unsigned mem_rem = 0;
   logic [15:0] mem_addr = 16'h0000;
   int unsigned lat = 1;

   int unsigned cyc = 0;
   int unsigned rd_count = 0;
   logic [15:0] last_rd_addr = 16'h0000;
   int unsigned rd_cycq[$];
   logic [15:0] rd_addrq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic        rd;
      logic [15:0] addr;
      logic        hold0;
      rd    = bus.imem_rd;
      addr  = bus.imem_addr;
      hold0 = m_hold;

      chk("instr_valid", 32'(bus.instr_valid), 32'(m_hold));
      if (m_hold) begin
         chk("instr", 32'(bus.instr), 32'(m_held_word));
         chk("instr_pc", 32'(bus.instr_pc), 32'(m_held_pc));
      end
      chk("retired_count", 32'(retired_count), 32'(m_retired));
      if (rd) begin
         chk("fetch_addr", 32'(addr), 32'(m_exp_addr));
         chk("single_outstanding", 32'(m_out | m_hold), 32'(1'b0));
         rd_count++;
         last_rd_addr = addr;
         rd_cycq.push_back(cyc);
         rd_addrq.push_back(addr);
      end
      if (reset || !gap_en || m_hold || m_out || rd) gap = 0;
      else begin
         gap++;
         chk("fetch_gap", 32'(gap <= 1), 32'(1'b1));
      end

      if (reset) begin
         m_exp_addr = 16'h0000;
         m_hold     = 1'b0;
         m_out      = 1'b0;
         m_orphan   = 1'b0;
         m_retired  = 16'h0000;
      end else begin
         if (bus.imem_rvalid && m_out) begin
            m_out = 1'b0;
            if (!m_orphan && !jump_valid) begin
               m_hold      = 1'b1;
               m_held_pc   = m_fetch_addr;
               m_held_word = m_fetch_addr ^ 16'hA5A5;
            end
            m_orphan = 1'b0;
         end else if (jump_valid && m_out) begin
            m_orphan = 1'b1;
         end
         if (jump_valid) begin
            m_exp_addr = jump_target;
            m_hold     = 1'b0;
         end else if (hold0 && bus.dec_ready) begin
            m_retired  = m_retired + 16'd1;
            m_hold     = 1'b0;
            m_exp_addr = bus.pc_increment ? m_held_pc + 16'd1 : m_held_pc;
         end
         if (rd) begin
            m_out        = 1'b1;
            m_orphan     = jump_valid;
            m_fetch_addr = addr;
         end
      end

      if (rd) begin
         mem_pend = 1'b1;
         mem_rem  = lat;
         mem_addr = addr;
      end
      if (reset && mem_rem > 1) mem_pend = 1'b0;

      @(posedge clock);
      #1;
      cyc++;
      bus.imem_rvalid = 1'b0;
      if (mem_pend) begin
         mem_rem--;
         if (mem_rem == 0) begin
            mem_pend        = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_addr ^ 16'hA5A5;
         end
      end
   endtask

   task automatic wait_rd(input string tag);
      int unsigned n  = 0;
      int unsigned c0 = rd_count;
      while (rd_count == c0 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(rd_count != c0), 32'(1'b1));
   endtask

   task automatic wait_valid(input string tag);
      int unsigned n = 0;
      while (!bus.instr_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.instr_valid), 32'(1'b1));
   endtask

   initial begin
      int unsigned base;
      int unsigned rd0;
      logic [15:0] r0;

      reset = 1'b1; jump_valid = 1'b0; jump_target = '0;
      step_mode = 1'b0; step_pulse = 1'b0;
      bus.dec_ready = 1'b1; bus.pc_increment = 1'b1;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

      // reset values
      @(posedge clock);
      #1;
      chk("rst_imem_rd", 32'(bus.imem_rd), 32'(1'b0));
      chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0000);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'(1'b0));
      chk("rst_instr", 32'(bus.instr), 32'h0000);
      chk("rst_instr_pc", 32'(bus.instr_pc), 32'h0000);
      chk("rst_retired", 32'(retired_count), 32'h0000);
      tick();
      reset = 1'b0;

      // free-run, 1-cycle memory: fetches at 0..3 every third cycle
      rd_cycq.delete(); rd_addrq.delete();
      base = cyc;
      repeat (13) tick();
      chk("free_run_retired", 32'(retired_count), 32'd4);
      chk("free_run_fetches", 32'(rd_cycq.size()), 32'd4);
      for (int k = 0; k < 4 && k < rd_cycq.size(); k++) begin
         chk("free_run_rd_cycle", 32'(rd_cycq[k] - base), 32'(1 + 3 * k));
         chk("free_run_rd_addr", 32'(rd_addrq[k]), 32'(k));
      end

      // decode stalls in HOLD
      bus.dec_ready = 1'b0;
      wait_valid("reach_hold");
      rd0 = rd_count;
      r0  = retired_count;
      repeat (5) tick();
      chk("stall_no_fetch", 32'(rd_count), 32'(rd0));
      chk("stall_retired", 32'(retired_count), 32'(r0));
      bus.dec_ready = 1'b1;
      tick();
      chk("stall_release", 32'(retired_count), 32'(r0 + 16'd1));

      // pc_increment=0 refetches the same address
      jump_target = 16'h0010; jump_valid = 1'b1;
      tick();
      jump_valid = 1'b0;
      wait_valid("valid_0010");
      chk("pc_0010", 32'(bus.instr_pc), 32'h0010);
      bus.pc_increment = 1'b0;
      tick();
      bus.pc_increment = 1'b1;
      wait_rd("refetch_rd");
      chk("refetch_addr", 32'(last_rd_addr), 32'h0010);

      // jump one cycle after REQ with latency 3: orphan is dropped
      wait_valid("valid_refetch");
      lat = 3;
      wait_rd("pre_jump_rd");
      jump_target = 16'h0200; jump_valid = 1'b1;
      tick();
      jump_valid = 1'b0;
      wait_rd("jump_rd");
      chk("jump_addr", 32'(last_rd_addr), 32'h0200);
      wait_valid("valid_0200");
      chk("jump_instr_pc", 32'(bus.instr_pc), 32'h0200);
      chk("jump_instr", 32'(bus.instr), 32'(16'h0200 ^ 16'hA5A5));

      // jump with dec_ready in HOLD: no retire
      r0 = retired_count;
      lat = 1;
      jump_target = 16'h0300; jump_valid = 1'b1; bus.dec_ready = 1'b1;
      tick();
      jump_valid = 1'b0;
      chk("jump_no_retire", 32'(retired_count), 32'(r0));
      wait_rd("jump_hold_rd");
      chk("jump_hold_addr", 32'(last_rd_addr), 32'h0300);

      // PC wrap from 0xFFFF, then reset while WAITing on the next fetch
      jump_target = 16'hFFFF; jump_valid = 1'b1;
      tick();
      jump_valid = 1'b0;
      wait_rd("ffff_rd");
      chk("ffff_addr", 32'(last_rd_addr), 32'hFFFF);
      wait_valid("valid_ffff");
      lat = 2;
      tick();
      wait_rd("wrap_rd");
      chk("wrap_addr", 32'(last_rd_addr), 32'h0000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("late_rvalid_present", 32'(bus.imem_rvalid), 32'(1'b1));
      tick();
      chk("late_return_ignored", 32'(bus.instr_valid), 32'(1'b0));
      chk("reset_retired", 32'(retired_count), 32'h0000);
      wait_rd("restart_rd");
      chk("restart_addr", 32'(last_rd_addr), 32'h0000);

      // single-step: pulses at 10 and 20 fetch; pulse at 12 lands in WAIT
      reset = 1'b1; step_mode = 1'b1; lat = 3;
      tick();
      reset = 1'b0; gap_en = 1'b0;
      rd_cycq.delete(); rd_addrq.delete();
      base = cyc;
      for (int t = 0; t < 30; t++) begin
         step_pulse = (t == 10 || t == 12 || t == 20);
         tick();
      end
      step_pulse = 1'b0;
      chk("step_fetches", 32'(rd_cycq.size()), 32'd2);
      if (rd_cycq.size() == 2) begin
         chk("step_rd0", 32'(rd_cycq[0] - base), 32'd11);
         chk("step_rd1", 32'(rd_cycq[1] - base), 32'd21);
      end
      chk("step_retired", 32'(retired_count), 32'd2);

      // randomized free-run against the scoreboard
      reset = 1'b1; step_mode = 1'b0;
      tick();
      reset = 1'b0; gap_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         jump_valid  = ($urandom % 12) == 0;
         jump_target = (($urandom % 4) == 0) ? 16'hFFFF - 16'($urandom % 2) : 16'($urandom);
         bus.dec_ready    = ($urandom % 10) < 7;
         bus.pc_increment = ($urandom % 5) != 0;
         reset = ($urandom % 150) == 0;
         lat   = 1 + ($urandom % 3);
         tick();
      end
      reset = 1'b0; jump_valid = 1'b0;
      chk("random_progress", 32'(rd_count > 100), 32'(1'b1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
